// File: rtl/output_scheduler.sv
// Output-port scheduler: round-robin arbitration over four input queues, packet-locked
// crossbar grant, and credit-based flow control toward the downstream router.
module output_scheduler #(
  parameter int unsigned CREDIT_DEPTH = 5,
  parameter int unsigned PACKET_FLITS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] request_din,
  input  logic       credit_din,
  output logic [3:0] conf_dout,
  output logic [3:0] pop_dout,
  output logic       valid_dout,
  output logic       credit_error_dout
);

  localparam logic [3:0] CreditMax = 4'(CREDIT_DEPTH);
  localparam logic [3:0] LastFlit  = 4'(PACKET_FLITS - 1);

  typedef enum logic {StIdle, StActive} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] rr_q, rr_d;
  logic [3:0] credit_q, credit_d;
  logic [3:0] flit_q, flit_d;
  logic       err_q, err_d;
  logic       valid_q;

  logic [1:0] cand;
  logic [1:0] arb_idx;
  logic       arb_hit;
  logic       transfer;

  // Round-robin search starting one past the last served port, wrapping back to it last.
  always_comb begin
    cand    = rr_q;
    arb_idx = rr_q;
    arb_hit = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_q + 2'(k);
      if (!arb_hit && request_din[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign transfer = (state_q == StActive) && request_din[grant_q] && (credit_q != 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= 2'd0;
      rr_q     <= 2'd3;
      credit_q <= CreditMax;
      flit_q   <= 4'd0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      credit_q <= credit_d;
      flit_q   <= flit_d;
      err_q    <= err_d;
      valid_q  <= |pop_dout;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    flit_d   = flit_q;
    credit_d = credit_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (arb_hit) begin
          grant_d = arb_idx;
          state_d = StActive;
          flit_d  = 4'd0;
        end
      end
      StActive: begin
        if (transfer) begin
          if (flit_q == LastFlit) begin
            state_d = StIdle;
            rr_d    = grant_q;
            flit_d  = 4'd0;
          end else begin
            flit_d = flit_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A credit arriving alongside a transfer cancels that transfer's debit.
    if (transfer && !credit_din) begin
      credit_d = credit_q - 4'd1;
    end else if (!transfer && credit_din) begin
      if (credit_q == CreditMax) err_d = 1'b1;
      else                       credit_d = credit_q + 4'd1;
    end
  end

  always_comb begin
    conf_dout = 4'b0000;
    if (state_q == StActive) conf_dout = 4'b0001 << grant_q;
    pop_dout = transfer ? conf_dout : 4'b0000;
  end

  assign valid_dout        = valid_q;
  assign credit_error_dout = err_q;

endmodule

// File: tb/tb_output_scheduler.sv
// Directed bench for output_scheduler: a packet-level reference model is checked every cycle,
// with literal expectations pinning latency, grant order, stalls, credit errors and reset.
module tb_output_scheduler;

  localparam int CD = 5;
  localparam int PF = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request_din;
  logic       credit_din;
  logic [3:0] conf_dout;
  logic [3:0] pop_dout;
  logic       valid_dout;
  logic       credit_error_dout;

  output_scheduler #(
    .CREDIT_DEPTH(CD),
    .PACKET_FLITS(PF)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .request_din      (request_din),
    .credit_din       (credit_din),
    .conf_dout        (conf_dout),
    .pop_dout         (pop_dout),
    .valid_dout       (valid_dout),
    .credit_error_dout(credit_error_dout)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: who owns the output, how many flits it has sent, credits on hand.
  bit m_busy;
  int m_port;
  int m_rr;
  int m_cred;
  int m_sent;
  bit m_err;
  bit m_valid;

  int         pop_seen;
  logic [3:0] prev_conf;
  logic [3:0] grants[$];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_port  = 0;
    m_rr    = 3;
    m_cred  = CD;
    m_sent  = 0;
    m_err   = 1'b0;
    m_valid = 1'b0;
  endtask

  function automatic bit m_xfer(input logic [3:0] req);
    return m_busy && req[m_port] && (m_cred > 0);
  endfunction

  // One clock cycle: drive inputs, compare outputs against the model, advance the model.
  task automatic step(input logic [3:0] req, input logic cred, input bit autocred);
    logic [3:0] exp_conf;
    bit         x;
    bit         found;
    request_din = req;
    x = m_xfer(req);
    credit_din = autocred ? x : cred;
    #1;
    exp_conf = m_busy ? (4'b0001 << m_port) : 4'b0000;
    chk("conf", conf_dout, exp_conf);
    chk("pop", pop_dout, x ? exp_conf : 4'b0000);
    chk("valid", {3'b000, valid_dout}, {3'b000, m_valid});
    chk("credit_error", {3'b000, credit_error_dout}, {3'b000, m_err});
    if (pop_dout != 4'b0000) pop_seen++;
    if (conf_dout != 4'b0000 && prev_conf == 4'b0000) grants.push_back(conf_dout);
    prev_conf = conf_dout;
    @(posedge clk);
    m_valid = x;
    if (x) begin
      m_cred = m_cred - 1 + (credit_din ? 1 : 0);
    end else if (credit_din) begin
      if (m_cred == CD) m_err = 1'b1;
      else              m_cred++;
    end
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && req[(m_rr + k) % 4]) begin
          found  = 1'b1;
          m_port = (m_rr + k) % 4;
        end
      end
      if (found) begin
        m_busy = 1'b1;
        m_sent = 0;
      end
    end else if (x) begin
      m_sent++;
      if (m_sent == PF) begin
        m_busy = 1'b0;
        m_rr   = m_port;
        m_sent = 0;
      end
    end
    @(negedge clk);
  endtask

  // Asserts reset between clock edges and checks the outputs clear with no clock edge.
  task automatic do_reset();
    reset = 1'b1;
    request_din = 4'b0000;
    credit_din  = 1'b0;
    #1;
    chk("rst conf", conf_dout, 4'b0000);
    chk("rst pop", pop_dout, 4'b0000);
    chk("rst valid", {3'b000, valid_dout}, 4'b0000);
    chk("rst credit_error", {3'b000, credit_error_dout}, 4'b0000);
    model_reset();
    prev_conf = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    request_din = 4'b0000;
    credit_din  = 1'b0;
    model_reset();
    @(negedge clk);

    // Single request: latency and packet length.
    do_reset();
    step(4'b0001, 1'b0, 1'b0);
    #1;
    chk("A conf N+1", conf_dout, 4'b0001);
    chk("A pop N+1", pop_dout, 4'b0001);
    chk("A valid N+1", {3'b000, valid_dout}, 4'b0000);
    pop_seen = 0;
    repeat (5) step(4'b0001, 1'b0, 1'b0);
    #1;
    chk("A conf N+6", conf_dout, 4'b0000);
    chk("A valid N+6", {3'b000, valid_dout}, 4'b0001);
    chk("A pops", 4'(pop_seen), 4'd5);
    step(4'b0000, 1'b0, 1'b0);
    repeat (5) step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);

    // All ports requesting: round-robin order with one idle gap per packet.
    do_reset();
    grants.delete();
    repeat (31) step(4'b1111, 1'b0, 1'b1);
    chk("B grant count", 4'(grants.size()), 4'd5);
    if (grants.size() == 5) begin
      chk("B grant0", grants[0], 4'b0001);
      chk("B grant1", grants[1], 4'b0010);
      chk("B grant2", grants[2], 4'b0100);
      chk("B grant3", grants[3], 4'b1000);
      chk("B grant4", grants[4], 4'b0001);
    end

    // Credit exhaustion: second packet is granted but stalls until a credit returns.
    do_reset();
    repeat (13) step(4'b0011, 1'b0, 1'b0);
    #1;
    chk("C stalled conf", conf_dout, 4'b0010);
    chk("C stalled pop", pop_dout, 4'b0000);
    step(4'b0011, 1'b1, 1'b0);
    #1;
    chk("C pop after credit", pop_dout, 4'b0010);
    step(4'b0011, 1'b0, 1'b0);
    #1;
    chk("C pop credits gone", pop_dout, 4'b0000);
    repeat (2) step(4'b0011, 1'b0, 1'b0);

    // Granted requester drops out mid-packet while others keep requesting.
    do_reset();
    pop_seen = 0;
    repeat (3) step(4'b0100, 1'b0, 1'b0);
    repeat (3) step(4'b1011, 1'b0, 1'b0);
    #1;
    chk("D conf held", conf_dout, 4'b0100);
    repeat (3) step(4'b0100, 1'b0, 1'b0);
    #1;
    chk("D conf done", conf_dout, 4'b0000);
    chk("D pops", 4'(pop_seen), 4'd5);
    step(4'b0000, 1'b0, 1'b0);

    // Credit returned while full: sticky error, counter unchanged.
    do_reset();
    step(4'b0000, 1'b1, 1'b0);
    #1;
    chk("E error set", {3'b000, credit_error_dout}, 4'b0001);
    repeat (3) step(4'b0000, 1'b0, 1'b0);
    chk("E error sticky", {3'b000, credit_error_dout}, 4'b0001);
    pop_seen = 0;
    repeat (8) step(4'b0001, 1'b0, 1'b0);
    chk("E pops", 4'(pop_seen), 4'd5);

    // Reset in the middle of flit 3 aborts the packet and restores bit-0 priority.
    do_reset();
    repeat (3) step(4'b0001, 1'b0, 1'b0);
    #1;
    chk("F pop flit3", pop_dout, 4'b0001);
    chk("F valid flit3", {3'b000, valid_dout}, 4'b0001);
    #1;
    do_reset();
    pop_seen = 0;
    step(4'b1111, 1'b0, 1'b0);
    #1;
    chk("F regrant", conf_dout, 4'b0001);
    repeat (6) step(4'b1111, 1'b0, 1'b0);
    chk("F pops", 4'(pop_seen), 4'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
